pipe_addsub: RTL and testbench

Parametrised, pipelined two-operand adder/subtractor for the datapath: WIDTH-bit operands, carry chain split into STAGES equal slices, one slice per clock. A valid/ready handshake on both sides gives one result per cycle at full throughput and stalls cleanly under backpressure. Flags (carry, signed overflow, zero) are produced alongside each result for ALU and branch logic.

---
 rtl/pipe_addsub.sv | 140 ++++++++++++++
 tb/tb_pipe_addsub.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined two-operand adder/subtractor with valid/ready on both sides.
// The WIDTH-bit carry chain is cut into STAGES slices of CW = WIDTH/STAGES bits,
// and one slice is resolved per stage.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_valid / o_ready   operand handshake (o_ready is combinational: !(o_valid && !i_ready))
//   i_op1, i_op2, i_sub operands; i_sub = 1 selects op1 - op2
//   o_valid / i_ready   result handshake
//   o_result            sum/difference modulo 2^WIDTH
//   o_carry             carry out of the MSB (1 = no borrow on subtraction)
//   o_overflow          two's-complement signed overflow
//   o_zero              o_result == 0
module pipe_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int unsigned CW = WIDTH / STAGES;
    localparam int unsigned SW = CW + 1;

    // Per-stage state. acc holds the beat as a rotating word: the slice about to be
    // added sits in the low CW bits, finished result slices enter from the top, so
    // after STAGES shifts the whole result is in place (deskew for free).
    // b holds the still-unprocessed slices of the effective second operand b'.
    logic             vld_q [STAGES];
    logic             vld_d [STAGES];
    logic [WIDTH-1:0] acc_q [STAGES];
    logic [WIDTH-1:0] acc_d [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic             cy_q  [STAGES];
    logic             cy_d  [STAGES];
    logic             ovf_q;
    logic             ovf_d;
    logic             zero_q;
    logic             zero_d;

    // Stage inputs and slice sums
    logic             in_vld [STAGES];
    logic [WIDTH-1:0] in_acc [STAGES];
    logic [WIDTH-1:0] in_b   [STAGES];
    logic             in_cy  [STAGES];
    logic [SW-1:0]    sum    [STAGES];

    logic             stall;

    // Global stall: only a held result at the output can block the pipe
    assign stall   = vld_q[STAGES-1] && !i_ready;
    assign o_ready = !stall;

    // Stage inputs: stage 0 takes the ports (b' and carry-in set by i_sub), others the previous stage
    always_comb begin
        in_vld[0] = i_valid;
        in_acc[0] = i_op1;
        in_b[0]   = i_sub ? ~i_op2 : i_op2;
        in_cy[0]  = i_sub;
        for (int k = 1; k < STAGES; k++) begin
            in_vld[k] = vld_q[k-1];
            in_acc[k] = acc_q[k-1];
            in_b[k]   = b_q[k-1];
            in_cy[k]  = cy_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            sum[k] = SW'(in_acc[k][CW-1:0]) + SW'(in_b[k][CW-1:0]) + SW'(in_cy[k]);
        end
    end

    // Next state: hold everything on stall; data registers only load with a valid beat
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k] = vld_q[k];
            acc_d[k] = acc_q[k];
            b_d[k]   = b_q[k];
            cy_d[k]  = cy_q[k];
        end
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_d[k] = in_vld[k];
                if (in_vld[k]) begin
                    acc_d[k] = (in_acc[k] >> CW) | (WIDTH'(sum[k][CW-1:0]) << (WIDTH - CW));
                    b_d[k]   = in_b[k] >> CW;
                    cy_d[k]  = sum[k][CW];
                end
            end
            // Last slice carries the operand MSBs, so signed overflow is resolved here
            if (in_vld[STAGES-1]) begin
                ovf_d  = (in_acc[STAGES-1][CW-1] == in_b[STAGES-1][CW-1]) &&
                         (sum[STAGES-1][CW-1] != in_acc[STAGES-1][CW-1]);
                zero_d = (acc_d[STAGES-1] == '0);
            end
        end
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                acc_q[k] <= '0;
                b_q[k]   <= '0;
                cy_q[k]  <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                acc_q[k] <= acc_d[k];
                b_q[k]   <= b_d[k];
                cy_q[k]  <= cy_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign o_valid    = vld_q[STAGES-1];
    assign o_result   = acc_q[STAGES-1];
    assign o_carry    = cy_q[STAGES-1];
    assign o_overflow = ovf_q;
    assign o_zero     = zero_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: self-checking bench for pipe_addsub.
// Main instance (WIDTH 32, STAGES 2) runs a vector table, backpressure and
// mid-stream reset sequences; four extra instances (32/1, 32/4, 32/8, 30/3)
// run random operands and random i_ready against a full-width reference model.
module tb_pipe_addsub;

    localparam int unsigned MS  = 2;
    localparam int          NSW = 4;
    localparam int unsigned SW_W [NSW] = '{32, 32, 32, 30};
    localparam int unsigned SW_S [NSW] = '{1, 4, 8, 3};

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
    } flags_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        flags_t      want;
    } vec_t;

    typedef struct {
        flags_t want;
        int     cyc;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance
    logic        m_valid, m_oready, m_sub, m_ovalid, m_iready, m_c, m_v, m_z;
    logic [31:0] m_op1, m_op2, m_res;

    pipe_addsub #(.WIDTH(32), .STAGES(MS)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (m_valid),
        .o_ready    (m_oready),
        .i_op1      (m_op1),
        .i_op2      (m_op2),
        .i_sub      (m_sub),
        .o_valid    (m_ovalid),
        .i_ready    (m_iready),
        .o_result   (m_res),
        .o_carry    (m_c),
        .o_overflow (m_v),
        .o_zero     (m_z)
    );

    // Sweep instances
    logic        sw_valid  [NSW];
    logic        sw_oready [NSW];
    logic        sw_sub    [NSW];
    logic        sw_ovalid [NSW];
    logic        sw_iready [NSW];
    logic        sw_c      [NSW];
    logic        sw_v      [NSW];
    logic        sw_z      [NSW];
    logic [31:0] sw_op1    [NSW];
    logic [31:0] sw_op2    [NSW];
    logic [31:0] sw_res    [NSW];

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        localparam int unsigned GW = SW_W[g];
        localparam int unsigned GS = SW_S[g];
        logic [GW-1:0] res_w;
        pipe_addsub #(.WIDTH(GW), .STAGES(GS)) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_valid    (sw_valid[g]),
            .o_ready    (sw_oready[g]),
            .i_op1      (sw_op1[g][GW-1:0]),
            .i_op2      (sw_op2[g][GW-1:0]),
            .i_sub      (sw_sub[g]),
            .o_valid    (sw_ovalid[g]),
            .i_ready    (sw_iready[g]),
            .o_result   (res_w),
            .o_carry    (sw_c[g]),
            .o_overflow (sw_v[g]),
            .o_zero     (sw_z[g])
        );
        assign sw_res[g] = 32'(res_w);
    end

    int     checks = 0;
    int     errors = 0;
    logic   lat_chk = 1'b0;
    sb_t    sbq [$];

    flags_t sw_exp  [NSW][16];
    int     sw_snap [NSW][16];
    int     sw_hd   [NSW];
    int     sw_tl   [NSW];
    int     sw_got  [NSW];
    int     adv     [NSW];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Independent full-width reference: mask to w bits, add with an extra carry bit
    function automatic flags_t ref_model(input int unsigned w, input logic [31:0] a,
                                         input logic [31:0] b, input logic sub);
        logic [32:0] mask, am, bm, sum;
        flags_t      f;
        mask  = (33'd1 << w) - 33'd1;
        am    = {1'b0, a} & mask;
        bm    = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        sum   = am + bm + 33'(sub);
        f.res = 32'(sum & mask);
        f.c   = sum[w];
        f.v   = (am[w-1] == bm[w-1]) && (sum[w-1] != am[w-1]);
        f.z   = ((sum & mask) == 33'd0);
        return f;
    endfunction

    function automatic flags_t outs();
        return {m_res, m_c, m_v, m_z};
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                input logic [31:0] res, input logic c, input logic v, input logic z);
        vec_t t;
        t.a = a; t.b = b; t.sub = sub;
        t.want = {res, c, v, z};
        return t;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        case ($urandom_range(0, 7))
            0: r = 32'h0000_0000;
            1: r = 32'hFFFF_FFFF;
            2: r = 32'h8000_0000;
            3: r = 32'h7FFF_FFFF;
            default: r = $urandom;
        endcase
        return r;
    endfunction

    // One main-instance cycle: drive, settle, score delivery/acceptance, wait for next negedge
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic rdy, input flags_t want,
                        output logic acc, output logic dlv, output logic ordy);
        sb_t e;
        m_valid = v; m_op1 = a; m_op2 = b; m_sub = sub; m_iready = rdy;
        #1;
        ordy = m_oready;
        acc  = v && m_oready;
        dlv  = m_ovalid && rdy;
        if (dlv) begin
            if (sbq.size() == 0) begin
                check("unexpected_beat", 64'(outs()), 64'(0));
            end else begin
                e = sbq.pop_front();
                check("result_flags", 64'(outs()), 64'(e.want));
                if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'(MS));
            end
        end
        if (acc) begin
            e.want = want;
            e.cyc  = cyc;
            sbq.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt [14];
        logic        acc, dlv, ordy, rdy, seen, bv;
        int          sent, got, stall_left, idx;
        flags_t      snap, f;
        logic [31:0] bp_a [5];
        logic [31:0] bp_b [5];
        logic        bp_s [5];

        rst_n = 1'b0;
        m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_sub = 1'b0; m_iready = 1'b0;
        for (int g = 0; g < NSW; g++) begin
            sw_valid[g] = 1'b0; sw_iready[g] = 1'b1; sw_sub[g] = 1'b0;
            sw_op1[g] = '0; sw_op2[g] = '0;
            sw_hd[g] = 0; sw_tl[g] = 0; sw_got[g] = 0; adv[g] = 0;
        end
        snap = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_o_valid", 64'(m_ovalid), 64'(0));
        check("rst_outputs", 64'(outs()), 64'(0));
        check("rst_o_ready", 64'(m_oready), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table, back-to-back with i_ready high
        vt[0]  = mk(32'd22,        32'd67,          1'b0, 32'd89,        1'b0, 1'b0, 1'b0);
        vt[1]  = mk(32'd600,       32'(-80),        1'b0, 32'd520,       1'b1, 1'b0, 1'b0);
        vt[2]  = mk(32'd244,       32'(-244),       1'b0, 32'd0,         1'b1, 1'b0, 1'b1);
        vt[3]  = mk(32'(-790),     32'd90,          1'b0, 32'hFFFF_FD44, 1'b0, 1'b0, 1'b0);
        vt[4]  = mk(32'd1234,      32'(-234),       1'b0, 32'd1000,      1'b1, 1'b0, 1'b0);
        vt[5]  = mk(32'd0,         32'd1,           1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        vt[6]  = mk(32'h7FFF_FFFF, 32'd1,           1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        vt[7]  = mk(32'h8000_0000, 32'd1,           1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        vt[8]  = mk(32'd5,         32'd5,           1'b1, 32'd0,         1'b1, 1'b0, 1'b1);
        vt[9]  = mk(32'hFFFF_FFFF, 32'd1,           1'b0, 32'd0,         1'b1, 1'b0, 1'b1);
        vt[10] = mk(32'h8000_0000, 32'h8000_0000,   1'b0, 32'd0,         1'b1, 1'b1, 1'b1);
        vt[11] = mk(32'h0000_FFFF, 32'd1,           1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        vt[12] = mk(32'h0001_0000, 32'd1,           1'b1, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0);
        vt[13] = mk(32'h1234_5678, 32'h1234_5679,   1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        lat_chk = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, vt[i].a, vt[i].b, vt[i].sub, 1'b1, vt[i].want, acc, dlv, ordy);
            check("table_accept", 64'(acc), 64'(1));
        end
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc, dlv, ordy);
        check("table_drained", 64'(sbq.size()), 64'(0));
        check("hold_o_valid", 64'(m_ovalid), 64'(0));
        check("hold_outputs", 64'(outs()), 64'(vt[13].want));

        // Backpressure: i_ready low for 3 cycles from the first o_valid
        lat_chk = 1'b0;
        bp_a = '{32'd10, 32'hFFFF_0000, 32'd77, 32'h8000_0001, 32'd3};
        bp_b = '{32'd20, 32'h0001_0000, 32'd78, 32'd2,         32'd3};
        bp_s = '{1'b0,   1'b0,          1'b1,   1'b1,          1'b1};
        sent = 0; got = 0; stall_left = 3; seen = 1'b0;
        for (int t = 0; t < 40 && got < 5; t++) begin
            rdy = 1'b1;
            if (m_ovalid) seen = 1'b1;
            if (seen && stall_left > 0) begin
                rdy = 1'b0;
                if (stall_left < 3) check("bp_hold", 64'(outs()), 64'(snap));
                else snap = outs();
                stall_left--;
            end
            bv  = (sent < 5);
            idx = (sent < 5) ? sent : 0;
            f   = ref_model(32, bp_a[idx], bp_b[idx], bp_s[idx]);
            step(bv, bp_a[idx], bp_b[idx], bp_s[idx], rdy, f, acc, dlv, ordy);
            if (!rdy) check("bp_o_ready", 64'(ordy), 64'(0));
            if (acc) sent++;
            if (dlv) got++;
        end
        check("bp_delivered", 64'(got), 64'(5));
        check("bp_queue_empty", 64'(sbq.size()), 64'(0));

        // Reset with two beats in flight
        step(1'b1, 32'd100, 32'd200, 1'b0, 1'b1, ref_model(32, 32'd100, 32'd200, 1'b0), acc, dlv, ordy);
        step(1'b1, 32'd300, 32'd5,   1'b1, 1'b1, ref_model(32, 32'd300, 32'd5,   1'b1), acc, dlv, ordy);
        check("pre_reset_valid", 64'(m_ovalid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_o_valid", 64'(m_ovalid), 64'(0));
        check("async_rst_outputs", 64'(outs()), 64'(0));
        check("async_rst_o_ready", 64'(m_oready), 64'(1));
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc, dlv, ordy);
            check("post_rst_idle", 64'(m_ovalid), 64'(0));
        end
        lat_chk = 1'b1;
        got = 0;
        step(1'b1, 32'd7, 32'd8, 1'b0, 1'b1, ref_model(32, 32'd7, 32'd8, 1'b0), acc, dlv, ordy);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc, dlv, ordy);
            if (dlv) got++;
        end
        check("post_rst_beat", 64'(got), 64'(1));
        check("post_rst_queue", 64'(sbq.size()), 64'(0));

        // Parameter sweep with random operands and random i_ready
        m_valid = 1'b0; m_iready = 1'b1;
        for (int t = 0; t < 700; t++) begin
            for (int g = 0; g < NSW; g++) begin
                sw_valid[g]  = (t < 640) && ($urandom_range(0, 3) != 0);
                sw_iready[g] = (t >= 640) || ($urandom_range(0, 3) != 0);
                sw_op1[g]    = rand_op();
                sw_op2[g]    = rand_op();
                sw_sub[g]    = 1'($urandom_range(0, 1));
            end
            #1;
            for (int g = 0; g < NSW; g++) begin
                if (sw_ovalid[g] && sw_iready[g]) begin
                    if (sw_hd[g] == sw_tl[g]) begin
                        check($sformatf("sweep%0d_unexpected", g), 64'(sw_res[g]), 64'(0));
                    end else begin
                        f = {sw_res[g], sw_c[g], sw_v[g], sw_z[g]};
                        check($sformatf("sweep%0d_result", g), 64'(f), 64'(sw_exp[g][sw_hd[g] % 16]));
                        check($sformatf("sweep%0d_latency", g),
                              64'(adv[g] - sw_snap[g][sw_hd[g] % 16]), 64'(SW_S[g] - 1));
                        sw_hd[g]++;
                        sw_got[g]++;
                    end
                end
                if (sw_valid[g] && sw_oready[g]) begin
                    sw_exp[g][sw_tl[g] % 16]  = ref_model(SW_W[g], sw_op1[g], sw_op2[g], sw_sub[g]);
                    sw_snap[g][sw_tl[g] % 16] = adv[g] + 1;
                    sw_tl[g]++;
                end
                if (sw_oready[g]) adv[g]++;
            end
            @(negedge clk);
        end
        for (int g = 0; g < NSW; g++) begin
            check($sformatf("sweep%0d_drained", g), 64'(sw_tl[g] - sw_hd[g]), 64'(0));
            check($sformatf("sweep%0d_enough", g), 64'(sw_got[g] > 100), 64'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
